// File: rtl/button_event_detector.sv
// Turns a debounced button level into edge pulses, short/long/double-click
// pulses and a running press count. One clock of latency on every output.
//
// state          | meaning
// ---------------+-------------------------------------------------------
// IDLE           | no gesture in progress
// PRESSED        | first click held, timing towards a long press
// LONG_HELD      | long press reported, waiting for release
// WAIT_SECOND    | first click released, double-click window open
// SECOND_PRESSED | second click held, a release now makes it a double

module button_event_detector #(
    parameter int LONG_PRESS_CYCLES    = 1000,
    parameter int DOUBLE_WINDOW_CYCLES = 500,
    parameter int COUNT_WIDTH          = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Debounced,
    output logic                   o_Press,
    output logic                   o_Release,
    output logic                   o_Short,
    output logic                   o_Long,
    output logic                   o_Double,
    output logic [COUNT_WIDTH-1:0] o_Count
);

    localparam int MAX_CYCLES  = (LONG_PRESS_CYCLES > DOUBLE_WINDOW_CYCLES) ?
                                 LONG_PRESS_CYCLES : DOUBLE_WINDOW_CYCLES;
    localparam int TIMER_WIDTH = $clog2(MAX_CYCLES);

    localparam logic [TIMER_WIDTH-1:0] LONG_LAST   = TIMER_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] WINDOW_LAST = TIMER_WIDTH'(DOUBLE_WINDOW_CYCLES - 1);

    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_PRESSED        = 3'd1;
    localparam logic [2:0] ST_LONG_HELD      = 3'd2;
    localparam logic [2:0] ST_WAIT_SECOND    = 3'd3;
    localparam logic [2:0] ST_SECOND_PRESSED = 3'd4;

    logic [2:0]             state;
    logic [2:0]             state_next;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   r_prev;
    logic                   rise;
    logic                   fall;
    logic                   timer_run;
    logic                   short_next;
    logic                   long_next;
    logic                   double_next;

    assign rise = i_Debounced & ~r_prev;
    assign fall = ~i_Debounced & r_prev;

    assign timer_run = (state == ST_PRESSED) ||
                       (state == ST_WAIT_SECOND) ||
                       (state == ST_SECOND_PRESSED);

    // Edges are checked before timer thresholds so a coincident edge wins.
    always_comb begin
        state_next  = state;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_next = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_next = ST_WAIT_SECOND;
                end else if (timer == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = ST_LONG_HELD;
                end
            end
            ST_LONG_HELD: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_SECOND: begin
                if (rise) begin
                    state_next = ST_SECOND_PRESSED;
                end else if (timer == WINDOW_LAST) begin
                    short_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_SECOND_PRESSED: begin
                if (fall) begin
                    double_next = 1'b1;
                    state_next  = ST_IDLE;
                end else if (timer == LONG_LAST) begin
                    // the first click is settled as short, the held second one as long
                    short_next = 1'b1;
                    long_next  = 1'b1;
                    state_next = ST_LONG_HELD;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state  <= ST_IDLE;
            timer  <= '0;
            r_prev <= 1'b0;
        end else begin
            state  <= state_next;
            r_prev <= i_Debounced;
            if (state_next != state) begin
                timer <= '0;
            end else if (timer_run) begin
                timer <= timer + TIMER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            o_Short   <= 1'b0;
            o_Long    <= 1'b0;
            o_Double  <= 1'b0;
            o_Count   <= '0;
        end else begin
            o_Press   <= rise;
            o_Release <= fall;
            o_Short   <= short_next;
            o_Long    <= long_next;
            o_Double  <= double_next;
            if (rise) begin
                o_Count <= o_Count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_button_event_detector.sv
// Randomised and directed bench for button_event_detector: a gesture-level
// model fills a scoreboard queue, a monitor pops it on every output pulse.

module tb_button_event_detector;

    localparam int L  = 8;
    localparam int D  = 6;
    localparam int CW = 4;

    localparam logic [4:0] EV_PRESS   = 5'b10000;
    localparam logic [4:0] EV_RELEASE = 5'b01000;
    localparam logic [4:0] EV_SHORT   = 5'b00100;
    localparam logic [4:0] EV_LONG    = 5'b00010;
    localparam logic [4:0] EV_DOUBLE  = 5'b00001;

    logic          i_Clk;
    logic          i_Rst_L;
    logic          i_Debounced;
    logic          o_Press;
    logic          o_Release;
    logic          o_Short;
    logic          o_Long;
    logic          o_Double;
    logic [CW-1:0] o_Count;

    button_event_detector #(
        .LONG_PRESS_CYCLES   (L),
        .DOUBLE_WINDOW_CYCLES(D),
        .COUNT_WIDTH         (CW)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Debounced(i_Debounced),
        .o_Press    (o_Press),
        .o_Release  (o_Release),
        .o_Short    (o_Short),
        .o_Long     (o_Long),
        .o_Double   (o_Double),
        .o_Count    (o_Count)
    );

    typedef struct {
        int            t;
        logic [4:0]    ev;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb_q[$];
    logic [4:0]    exp_ev[int];
    logic [CW-1:0] exp_cnt[int];
    int            seg_lvl[$];
    int            seg_len[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_fails  = 0;

    // gesture-level reference state
    int m_level    = 0;
    int m_pending  = 0;
    int m_rel      = 0;
    int m_press_t  = 0;
    int m_second   = 0;
    int m_presses  = 0;

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    always @(posedge i_Clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic add_ev(input int t, input logic [4:0] mask);
        if (exp_ev.exists(t)) exp_ev[t] = exp_ev[t] | mask;
        else                  exp_ev[t] = mask;
        exp_cnt[t] = CW'(m_presses);
    endtask

    task automatic model_rise(input int t);
        if (m_pending != 0 && (t - m_rel) > D) begin
            add_ev(m_rel + D, EV_SHORT);
            m_pending = 0;
        end
        m_presses++;
        add_ev(t, EV_PRESS);
        m_second  = m_pending;
        m_pending = 0;
        m_press_t = t;
    endtask

    task automatic model_fall(input int t);
        bit held_long;
        held_long = (t - m_press_t) > L;
        add_ev(t, EV_RELEASE);
        if (m_second != 0) begin
            if (held_long) add_ev(m_press_t + L, EV_SHORT | EV_LONG);
            else           add_ev(t, EV_DOUBLE);
        end else if (held_long) begin
            add_ev(m_press_t + L, EV_LONG);
        end else begin
            m_pending = 1;
            m_rel     = t;
        end
        m_second = 0;
    endtask

    task automatic seg(input int lvl, input int len);
        seg_lvl.push_back(lvl);
        seg_len.push_back(len);
    endtask

    // Model the queued segments, load the scoreboard, then drive them.
    task automatic run_phase();
        int   t;
        exp_t e;
        t = cyc + 1;
        for (int i = 0; i < seg_lvl.size(); i++) begin
            if (seg_lvl[i] != m_level) begin
                if (seg_lvl[i] != 0) model_rise(t);
                else                 model_fall(t);
                m_level = seg_lvl[i];
            end
            t += seg_len[i];
        end
        if (m_pending != 0 && (m_rel + D) < t) begin
            add_ev(m_rel + D, EV_SHORT);
            m_pending = 0;
        end
        foreach (exp_ev[k]) begin
            e.t   = k;
            e.ev  = exp_ev[k];
            e.cnt = exp_cnt[k];
            sb_q.push_back(e);
        end
        exp_ev.delete();
        exp_cnt.delete();
        for (int i = 0; i < seg_lvl.size(); i++) begin
            i_Debounced = (seg_lvl[i] != 0);
            repeat (seg_len[i]) begin
                @(posedge i_Clk);
                #1;
            end
        end
        seg_lvl.delete();
        seg_len.delete();
    endtask

    task automatic do_reset(input logic level);
        check_eq("queue_empty_at_reset", sb_q.size(), 0);
        sb_q.delete();
        i_Rst_L     = 1'b0;
        i_Debounced = level;
        m_level   = 0;
        m_pending = 0;
        m_second  = 0;
        m_presses = 0;
        repeat (3) begin
            @(negedge i_Clk);
            check_eq("reset_outputs",
                     int'({o_Press, o_Release, o_Short, o_Long, o_Double, o_Count}), 0);
        end
        @(posedge i_Clk);
        #1;
        i_Rst_L = 1'b1;
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            seg(1, $urandom_range(1, L + 3));
            seg(0, $urandom_range(1, D + 3));
        end
        seg(0, D + 3);
        run_phase();
    endtask

    logic [4:0] mon_pulses;
    exp_t       mon_e;

    always @(negedge i_Clk) begin
        if (i_Rst_L) begin
            mon_pulses = {o_Press, o_Release, o_Short, o_Long, o_Double};
            if (mon_pulses != 5'b0 || (sb_q.size() != 0 && sb_q[0].t <= cyc)) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_pulse: got pulses %b count %0d at cycle %0d, expected none",
                             mon_pulses, o_Count, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.t != cyc || mon_e.ev != mon_pulses || mon_e.cnt != o_Count) begin
                        n_fails++;
                        $display("FAIL event: got pulses %b count %0d at cycle %0d, expected pulses %b count %0d at cycle %0d",
                                 mon_pulses, o_Count, cyc, mon_e.ev, mon_e.cnt, mon_e.t);
                    end
                end
            end
        end
    end

    initial begin
        i_Rst_L     = 1'b0;
        i_Debounced = 1'b0;
        do_reset(1'b0);
        seg(0, 5);
        run_phase();

        // short click
        seg(1, 3); seg(0, D + 3);
        run_phase();
        // long press
        seg(1, 20); seg(0, 4);
        run_phase();
        // double click
        seg(1, 3); seg(0, 2); seg(1, 3); seg(0, D + 3);
        run_phase();
        // second rise at the last cycle of the window
        seg(1, 3); seg(0, D); seg(1, 3); seg(0, D + 3);
        run_phase();
        // second rise one cycle past the window
        seg(1, 3); seg(0, D + 1); seg(1, 3); seg(0, D + 3);
        run_phase();
        // release on the long-threshold cycle
        seg(1, L); seg(0, D + 3);
        run_phase();

        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            seg(1, 3); seg(0, D + 2);
        end
        run_phase();
        @(negedge i_Clk);
        check_eq("count_wrap", int'(o_Count), 1);
        @(posedge i_Clk);
        #1;

        for (int p = 0; p < 4; p++) random_phase(40);

        // reset in the double-click window discards the pending short
        seg(1, 3); seg(0, 2);
        run_phase();
        do_reset(1'b0);
        seg(0, D + 6);
        run_phase();

        // input high through reset reports a press right after release
        do_reset(1'b1);
        seg(1, 4); seg(0, D + 3);
        run_phase();

        check_eq("queue_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
